// File: rtl/audio_pkg.sv
// Shared audio-path constants and the coefficient loader's commit-FSM encoding.
package audio_pkg;

    localparam int FIR_COEF_BITS     = 16;
    localparam int FIR_TAP_ADDR_BITS = 8;
    localparam int NUM_FILTERS       = 4;

    typedef logic [1:0] coef_ld_state_t;

    localparam coef_ld_state_t ST_IDLE       = 2'd0;
    localparam coef_ld_state_t ST_WAIT_GRANT = 2'd1;
    localparam coef_ld_state_t ST_WRITE      = 2'd2;

endpackage

// File: rtl/coef_fifo.sv
// Small synchronous FIFO holding pending coefficient writes; head is the oldest entry.
module coef_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push while full is refused even if a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Turns SPI coefficient strobes into queued {filter, tap} RAM writes, committed only
// while the FIR engine grants the RAM; tracks per-filter completion and error flags.
module fir_coef_loader #(
    parameter int NUM_FILTERS      = audio_pkg::NUM_FILTERS,
    parameter int FILTER_ADDR_BITS = 2,
    parameter int TAP_ADDR_BITS    = audio_pkg::FIR_TAP_ADDR_BITS,
    parameter int COEF_BITS        = audio_pkg::FIR_COEF_BITS,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    coef_wr_stb,
    input  logic [7:0]                              coef_lsb,
    input  logic [7:0]                              coef_msb,
    input  logic [7:0]                              filter_select,
    input  logic [7:0]                              taps_per_filter,
    input  logic                                    tap_clear,
    input  logic                                    ram_grant,
    output logic                                    ram_wr_en,
    output logic [FILTER_ADDR_BITS+TAP_ADDR_BITS-1:0] ram_wr_addr,
    output logic [COEF_BITS-1:0]                    ram_wr_data,
    output logic [7:0]                              tap_ptr,
    output logic [NUM_FILTERS-1:0]                  filter_loaded,
    output logic                                    overflow,
    output logic                                    sel_err,
    output logic                                    busy,
    output logic [1:0]                              dbg_state
);

    import audio_pkg::*;

    localparam int AW    = FILTER_ADDR_BITS + TAP_ADDR_BITS;
    localparam int EW    = 1 + AW + COEF_BITS;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] NF8 = 8'(NUM_FILTERS);

    logic [7:0]                  tap_q, tap_d, tap_base, prev_sel_q;
    logic [NUM_FILTERS-1:0]      loaded_q, loaded_d;
    logic                        ovf_q, ovf_d, selerr_q, selerr_d;
    coef_ld_state_t              state_q, state_d;
    logic                        sel_ok, sel_change, last;
    logic                        do_push, do_pop;
    logic                        fifo_full, fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic [EW-1:0]               push_data, head;
    logic [FILTER_ADDR_BITS-1:0] sel_idx, head_filter;
    logic                        head_last;

    assign sel_ok      = (filter_select < NF8);
    assign sel_change  = (filter_select != prev_sel_q);
    assign sel_idx     = filter_select[FILTER_ADDR_BITS-1:0];
    // Filter change or tap_clear restart the pointer before a same-cycle strobe is tagged.
    assign tap_base    = (sel_change || tap_clear) ? 8'd0 : tap_q;
    assign last        = (tap_base == (taps_per_filter - 8'd1));
    assign do_push     = coef_wr_stb && sel_ok && !fifo_full;
    assign push_data   = {last, sel_idx, TAP_ADDR_BITS'(tap_base), COEF_BITS'({coef_msb, coef_lsb})};
    assign head_last   = head[EW-1];
    assign head_filter = head[COEF_BITS+TAP_ADDR_BITS +: FILTER_ADDR_BITS];

    coef_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (do_push),
        .data_i  (push_data),
        .pop_i   (do_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head),
        .count_o (fifo_count)
    );

    always_comb begin
        tap_d    = tap_base;
        ovf_d    = tap_clear ? 1'b0 : ovf_q;
        selerr_d = tap_clear ? 1'b0 : selerr_q;
        loaded_d = loaded_q;
        if (tap_clear && sel_ok) loaded_d[sel_idx] = 1'b0;
        if (do_push) tap_d = last ? 8'd0 : tap_base + 8'd1;
        if (coef_wr_stb && !sel_ok) selerr_d = 1'b1;
        if (coef_wr_stb && sel_ok && fifo_full) ovf_d = 1'b1;
        if (do_pop && head_last) loaded_d[head_filter] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        do_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_WAIT_GRANT;
            end
            ST_WAIT_GRANT: begin
                if (ram_grant) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_WAIT_GRANT;
                if (ram_grant) begin
                    do_pop = 1'b1;
                    if (fifo_count == CNT_W'(1) && !do_push) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_q      <= '0;
            prev_sel_q <= '0;
            loaded_q   <= '0;
            ovf_q      <= 1'b0;
            selerr_q   <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            tap_q      <= tap_d;
            prev_sel_q <= filter_select;
            loaded_q   <= loaded_d;
            ovf_q      <= ovf_d;
            selerr_q   <= selerr_d;
            state_q    <= state_d;
        end
    end

    assign ram_wr_en     = do_pop;
    assign ram_wr_addr   = do_pop ? head[COEF_BITS +: AW] : '0;
    assign ram_wr_data   = do_pop ? head[COEF_BITS-1:0] : '0;
    assign tap_ptr       = tap_q;
    assign filter_loaded = loaded_q;
    assign overflow      = ovf_q;
    assign sel_err       = selerr_q;
    assign busy          = !fifo_empty || (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomised bench for fir_coef_loader against a queue-based model of the enqueue rules.
module tb_fir_coef_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        coef_wr_stb;
    logic [7:0]  coef_lsb, coef_msb, filter_select, taps_per_filter;
    logic        tap_clear, ram_grant;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic [7:0]  tap_ptr;
    logic [3:0]  filter_loaded;
    logic        overflow, sel_err, busy;
    logic [1:0]  dbg_state;

    fir_coef_loader dut (
        .clk             (clk),
        .reset           (reset),
        .coef_wr_stb     (coef_wr_stb),
        .coef_lsb        (coef_lsb),
        .coef_msb        (coef_msb),
        .filter_select   (filter_select),
        .taps_per_filter (taps_per_filter),
        .tap_clear       (tap_clear),
        .ram_grant       (ram_grant),
        .ram_wr_en       (ram_wr_en),
        .ram_wr_addr     (ram_wr_addr),
        .ram_wr_data     (ram_wr_data),
        .tap_ptr         (tap_ptr),
        .filter_loaded   (filter_loaded),
        .overflow        (overflow),
        .sel_err         (sel_err),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: expected writes are {last, filter[1:0], tap[7:0], data[15:0]}.
    logic [26:0] exp_q[$];
    logic [25:0] obs_q[$];
    int          obs_cyc_q[$];
    int          m_tap = 0;
    logic [7:0]  m_sel = 8'd0;
    logic [3:0]  m_loaded = 4'd0;
    bit          m_ovf = 0, m_selerr = 0;
    int          n_push = 0, n_pop = 0;
    int          stb_cyc = 0;
    bit          en_bad = 0;

    always @(negedge clk) begin
        if (ram_wr_en === 1'b1) begin
            obs_q.push_back({ram_wr_addr, ram_wr_data});
            obs_cyc_q.push_back(cyc);
            n_pop <= n_pop + 1;
            if (ram_grant !== 1'b1) en_bad <= 1'b1;
        end
    end

    task automatic do_strobe(input logic [7:0] sel, input logic [15:0] data, input bit clr);
        bit lst;
        @(negedge clk);
        filter_select = sel;
        coef_msb      = data[15:8];
        coef_lsb      = data[7:0];
        coef_wr_stb   = 1'b1;
        tap_clear     = clr;
        if (sel != m_sel || clr) m_tap = 0;
        m_sel = sel;
        if (clr) begin
            m_ovf    = 0;
            m_selerr = 0;
            if (sel < 8'd4) m_loaded[sel[1:0]] = 1'b0;
        end
        if (sel >= 8'd4) begin
            m_selerr = 1;
        end else if (n_push - n_pop >= 4) begin
            m_ovf = 1;
        end else begin
            lst = (m_tap == (int'(taps_per_filter) + 255) % 256);
            exp_q.push_back({lst, sel[1:0], 8'(m_tap), data});
            n_push++;
            if (lst) m_loaded[sel[1:0]] = 1'b1;
            m_tap = lst ? 0 : (m_tap + 1) % 256;
        end
        @(posedge clk);
        #1;
        stb_cyc     = cyc;
        coef_wr_stb = 1'b0;
        tap_clear   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (tap_ptr !== 8'd0) begin n_fail++; $display("FAIL reset_tap_ptr: got %0h expected 0", tap_ptr); end
        n_tests++; if (ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", ram_wr_en); end
        n_tests++; if (ram_wr_addr !== 10'd0 || ram_wr_data !== 16'd0) begin n_fail++; $display("FAIL reset_addr_data: got %0h/%0h expected 0/0", ram_wr_addr, ram_wr_data); end
        n_tests++; if (filter_loaded !== 4'd0) begin n_fail++; $display("FAIL reset_loaded: got %0b expected 0", filter_loaded); end
        n_tests++; if (overflow !== 1'b0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b sel=%0b expected 0/0", overflow, sel_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_basic_load();
        logic [26:0] e;
        logic [25:0] o;
        int lat;
        bit to;
        taps_per_filter = 8'd4;
        ram_grant       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_strobe(8'd1, 16'h0100 + 16'(i), 1'b0);
            repeat (5) @(negedge clk);
            lat = (obs_cyc_q.size() == 1) ? obs_cyc_q[0] - stb_cyc : -1;
            n_tests++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat); end
            obs_cyc_q.delete();
        end
        wait_idle(20, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_idle: got busy expected idle"); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL basic_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (filter_loaded !== m_loaded) begin n_fail++; $display("FAIL basic_loaded: got %0b expected %0b", filter_loaded, m_loaded); end
        n_tests++; if (tap_ptr !== 8'(m_tap)) begin n_fail++; $display("FAIL basic_tap_ptr: got %0d expected %0d", tap_ptr, m_tap); end
    endtask

    task automatic test_grant_block();
        logic [26:0] e;
        logic [25:0] o;
        bit to;
        taps_per_filter = 8'd8;
        ram_grant       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_strobe(8'd1, 16'($urandom), 1'b0);
            @(negedge clk);
        end
        n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL block_overflow: got %0b expected %0b", overflow, m_ovf); end
        n_tests++; if (tap_ptr !== 8'(m_tap)) begin n_fail++; $display("FAIL block_tap_ptr: got %0d expected %0d", tap_ptr, m_tap); end
        n_tests++; if (busy !== 1'b1 || obs_q.size() != 0) begin n_fail++; $display("FAIL block_hold: got busy=%0b writes=%0d expected 1/0", busy, obs_q.size()); end
        @(negedge clk);
        ram_grant = 1'b1;
        wait_idle(60, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL block_idle: got busy expected idle"); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL block_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL block_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_grant_drop();
        logic [26:0] e;
        logic [25:0] o;
        bit to;
        ram_grant = 1'b0;
        do_strobe(8'd1, 16'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        ram_grant = 1'b1;
        @(posedge clk);
        #1 ram_grant = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_wr_en !== 1'b0 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL drop_in_write: got en=%0b state=%0d expected 0/2", ram_wr_en, dbg_state); end
        @(negedge clk);
        n_tests++; if (dbg_state !== 2'd1 || busy !== 1'b1 || obs_q.size() != 0) begin n_fail++; $display("FAIL drop_return: got state=%0d busy=%0b writes=%0d expected 1/1/0", dbg_state, busy, obs_q.size()); end
        repeat (3) @(negedge clk);
        ram_grant = 1'b1;
        wait_idle(20, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL drop_idle: got busy expected idle"); end
        n_tests++; if (obs_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL drop_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL drop_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (en_bad) begin n_fail++; $display("FAIL wr_en_without_grant: got 1 expected 0"); end
    endtask

    task automatic test_filter_change();
        logic [26:0] e;
        logic [25:0] o;
        bit to;
        ram_grant       = 1'b1;
        taps_per_filter = 8'd8;
        do_strobe(8'd0, 16'($urandom), 1'b0);
        repeat (5) @(negedge clk);
        do_strobe(8'd0, 16'($urandom), 1'b0);
        repeat (5) @(negedge clk);
        do_strobe(8'd2, 16'($urandom), 1'b0);
        wait_idle(20, to);
        n_tests++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL change_count: got %0d expected 3", obs_q.size()); end
        o = '0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL change_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (o[25:16] !== 10'h200) begin n_fail++; $display("FAIL change_addr: got %0h expected 200", o[25:16]); end
        n_tests++; if (tap_ptr !== 8'(m_tap)) begin n_fail++; $display("FAIL change_tap_ptr: got %0d expected %0d", tap_ptr, m_tap); end
        n_tests++; if (filter_loaded[0] !== 1'b0) begin n_fail++; $display("FAIL change_loaded0: got %0b expected 0", filter_loaded[0]); end
    endtask

    task automatic test_boundaries();
        logic [26:0] e;
        logic [25:0] o;
        bit to;
        int bad;
        ram_grant       = 1'b1;
        taps_per_filter = 8'd0;
        for (int i = 0; i < 256; i++) begin
            do_strobe(8'd3, 16'($urandom), 1'b0);
            repeat (3) @(negedge clk);
            n_tests++; if (tap_ptr !== 8'(m_tap)) begin n_fail++; $display("FAIL wrap_tap_ptr: got %0d expected %0d", tap_ptr, m_tap); end
        end
        wait_idle(20, to);
        n_tests++; if (obs_q.size() != 256) begin n_fail++; $display("FAIL wrap_count: got %0d expected 256", obs_q.size()); end
        bad = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e[25:0]) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap_writes: got %0d wrong expected 0", bad); end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (filter_loaded[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_loaded: got %0b expected 1", filter_loaded[3]); end

        do_strobe(8'd5, 16'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        n_tests++; if (sel_err !== m_selerr) begin n_fail++; $display("FAIL range_sel_err: got %0b expected %0b", sel_err, m_selerr); end
        n_tests++; if (obs_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL range_no_write: got writes=%0d busy=%0b expected 0/0", obs_q.size(), busy); end

        do_strobe(8'd1, 16'($urandom), 1'b1);
        wait_idle(20, to);
        n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL clear_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL clear_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (tap_ptr !== 8'(m_tap)) begin n_fail++; $display("FAIL clear_tap_ptr: got %0d expected %0d", tap_ptr, m_tap); end
        n_tests++; if (overflow !== 1'b0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL clear_flags: got ovf=%0b sel=%0b expected 0/0", overflow, sel_err); end
        n_tests++; if (filter_loaded !== m_loaded) begin n_fail++; $display("FAIL clear_loaded: got %0b expected %0b", filter_loaded, m_loaded); end
    endtask

    task automatic test_random();
        logic [26:0] e;
        logic [25:0] o;
        logic [7:0]  sel;
        bit to;
        ram_grant       = 1'b1;
        taps_per_filter = 8'($urandom_range(1, 5));
        for (int i = 0; i < 40; i++) begin
            sel = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            do_strobe(sel, 16'($urandom), $urandom_range(0, 7) == 0);
            repeat (4) @(negedge clk);
            n_tests++; if (tap_ptr !== 8'(m_tap) || sel_err !== m_selerr || overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_state: got tap=%0d sel=%0b ovf=%0b expected %0d/%0b/%0b", tap_ptr, sel_err, overflow, m_tap, m_selerr, m_ovf);
            end
        end
        wait_idle(20, to);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e[25:0]) begin n_fail++; $display("FAIL rand_write: got %0h expected %0h", o, e[25:0]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        n_tests++; if (filter_loaded !== m_loaded) begin n_fail++; $display("FAIL rand_loaded: got %0b expected %0b", filter_loaded, m_loaded); end
    endtask

    task automatic test_reset_mid_queue();
        ram_grant       = 1'b0;
        taps_per_filter = 8'd8;
        for (int i = 0; i < 3; i++) do_strobe(8'd2, 16'($urandom), 1'b0);
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midq_pending: got busy=%0b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        m_tap = 0; m_ovf = 0; m_selerr = 0; m_loaded = 4'd0;
        m_sel = filter_select;
        exp_q.delete();
        n_push = n_pop;
        n_tests++; if (tap_ptr !== 8'd0 || busy !== 1'b0 || ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL midq_async: got tap=%0d busy=%0b en=%0b expected 0/0/0", tap_ptr, busy, ram_wr_en); end
        n_tests++; if (filter_loaded !== 4'd0 || overflow !== 1'b0 || sel_err !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL midq_flags: got loaded=%0b ovf=%0b sel=%0b state=%0d expected 0", filter_loaded, overflow, sel_err, dbg_state);
        end
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        ram_grant = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if (obs_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midq_no_write: got writes=%0d busy=%0b expected 0/0", obs_q.size(), busy); end
        obs_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        reset           = 1'b1;
        coef_wr_stb     = 1'b0;
        coef_lsb        = 8'd0;
        coef_msb        = 8'd0;
        filter_select   = 8'd0;
        taps_per_filter = 8'd4;
        tap_clear       = 1'b0;
        ram_grant       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_basic_load();
        test_grant_block();
        test_grant_drop();
        test_filter_change();
        test_boundaries();
        test_random();
        test_reset_mid_queue();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
